// File: rtl/alu_pkg.sv
// Shared definitions for the registered execute-stage ALU.
package alu_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [3:0] {
    OP_OR   = 4'd0,
    OP_AND  = 4'd1,
    OP_NAND = 4'd2,
    OP_NOR  = 4'd3,
    OP_NOT  = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADD  = 4'd6,
    OP_SUB  = 4'd7,
    OP_SHL  = 4'd8,
    OP_SHR  = 4'd9,
    OP_CMP  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for ADD and SUB: SUB is a + ~b + 1 through the same carry chain.
module alu_addsub #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_carry,
  output logic         o_ovf
);

  logic [W-1:0] w_bOp;
  logic [W:0]   w_sum;

  assign w_bOp = i_sub ? ~i_b : i_b;
  assign w_sum = {1'b0, i_a} + {1'b0, w_bOp} + {{W{1'b0}}, i_sub};

  assign o_sum   = w_sum[W-1:0];
  assign o_carry = w_sum[W];
  // Operands of equal sign (after the B inversion) producing a result of the other sign.
  assign o_ovf   = (i_a[W-1] == w_bOp[W-1]) && (w_sum[W-1] != i_a[W-1]);

endmodule

// File: rtl/alu32_reg.sv
// Registered 32-bit ALU: result and flags computed combinationally, captured on in_valid.
module alu32_reg
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             carry_flag,
  output logic             neg_flag,
  output logic             zero_flag,
  output logic             overflow_flag
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] LP_WLIM = WIDTH;

  alu_op_e          w_op;
  logic [WIDTH-1:0] w_sum;
  logic             w_sumCarry;
  logic             w_sumOvf;
  logic [SHW-1:0]   w_rot;
  logic [SHW:0]     w_rotInv;
  logic             w_shOver;
  logic [WIDTH-1:0] w_y;
  logic             w_carry;
  logic             w_ovf;

  logic             r_valid;
  logic [WIDTH-1:0] r_y;
  logic             r_carry;
  logic             r_neg;
  logic             r_zero;
  logic             r_ovf;

  assign w_op = alu_op_e'(alu_control);

  alu_addsub #(.W(WIDTH)) u_addsub (
    .i_a     (a),
    .i_b     (b),
    .i_sub   (w_op == OP_SUB),
    .o_sum   (w_sum),
    .o_carry (w_sumCarry),
    .o_ovf   (w_sumOvf)
  );

  // Rotates use only the low bits of b; the complementary shift is WIDTH - amount,
  // which for amount 0 shifts everything out and leaves a unchanged.
  assign w_rot    = b[SHW-1:0];
  assign w_rotInv = {1'b1, {SHW{1'b0}}} - {1'b0, w_rot};
  assign w_shOver = (b >= LP_WLIM);

  always_comb begin
    w_y     = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (w_op)
      OP_OR:   w_y = a | b;
      OP_AND:  w_y = a & b;
      OP_NAND: w_y = ~(a & b);
      OP_NOR:  w_y = ~(a | b);
      OP_NOT:  w_y = ~a;
      OP_XOR:  w_y = a ^ b;
      OP_ADD, OP_SUB: begin
        w_y     = w_sum;
        w_carry = w_sumCarry;
        w_ovf   = w_sumOvf;
      end
      OP_SHL:  w_y = w_shOver ? '0 : (a << b);
      OP_SHR:  w_y = w_shOver ? '0 : (a >> b);
      OP_CMP: begin
        if (a == b)     w_y = '0;
        else if (a > b) w_y = {{(WIDTH-1){1'b0}}, 1'b1};
        else            w_y = '1;
      end
      OP_ROL:  w_y = (a << w_rot) | (a >> w_rotInv);
      OP_ROR:  w_y = (a >> w_rot) | (a << w_rotInv);
      default: w_y = '0;
    endcase
  end

  // Result and all flags load together; an idle cycle only clears out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_y     <= '0;
      r_carry <= 1'b0;
      r_neg   <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_y     <= w_y;
        r_carry <= w_carry;
        r_neg   <= w_y[WIDTH-1];
        r_zero  <= (w_y == '0);
        r_ovf   <= w_ovf;
      end
    end
  end

  assign out_valid     = r_valid;
  assign y             = r_y;
  assign carry_flag    = r_carry;
  assign neg_flag      = r_neg;
  assign zero_flag     = r_zero;
  assign overflow_flag = r_ovf;

endmodule

// File: tb/tb_alu32_reg.sv
// Directed self-checking bench for alu32_reg; expected values are hand-computed.
module tb_alu32_reg;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    logic [3:0]  f;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic [31:0] y;
  logic        carry_flag;
  logic        neg_flag;
  logic        zero_flag;
  logic        overflow_flag;

  int nTests = 0;
  int nFail  = 0;

  alu32_reg dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .alu_control   (alu_control),
    .out_valid     (out_valid),
    .y             (y),
    .carry_flag    (carry_flag),
    .neg_flag      (neg_flag),
    .zero_flag     (zero_flag),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {out_valid, y, carry, neg, zero, ovf}.
  function automatic logic [36:0] obs();
    return {out_valid, y, carry_flag, neg_flag, zero_flag, overflow_flag};
  endfunction

  task automatic issue(input logic [3:0] op, input logic [31:0] aa, input logic [31:0] bb);
    in_valid    = 1'b1;
    alu_control = op;
    a           = aa;
    b           = bb;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
  endtask

  task automatic test_reset();
    nTests++;
    if (obs() !== 37'h0) begin
      nFail++;
      $display("[TB] FAIL reset_init: got %h want %h", obs(), 37'h0);
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(4'd6, 32'h1, 32'h2);
    nTests++;
    if (obs() !== {1'b1, 32'h3, 4'b0000}) begin
      nFail++;
      $display("[TB] FAIL reset_first_add: got %h want %h", obs(), {1'b1, 32'h3, 4'b0000});
    end
    issue(4'd6, 32'h7FFF_FFFF, 32'h1);
    @(posedge clk);
    #1;
    nTests++;
    if (obs() !== {1'b0, 32'h8000_0000, 4'b0101}) begin
      nFail++;
      $display("[TB] FAIL idle_hold: got %h want %h", obs(), {1'b0, 32'h8000_0000, 4'b0101});
    end
    in_valid    = 1'b1;
    alu_control = 4'd6;
    a           = 32'd5;
    b           = 32'd6;
    #3;
    rst_n = 1'b0;
    #1;
    nTests++;
    if (obs() !== 37'h0) begin
      nFail++;
      $display("[TB] FAIL reset_async: got %h want %h", obs(), 37'h0);
    end
    @(posedge clk);
    #1;
    nTests++;
    if (obs() !== 37'h0) begin
      nFail++;
      $display("[TB] FAIL reset_held: got %h want %h", obs(), 37'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nTests++;
    if (obs() !== {1'b1, 32'd11, 4'b0000}) begin
      nFail++;
      $display("[TB] FAIL reset_release: got %h want %h", obs(), {1'b1, 32'd11, 4'b0000});
    end
  endtask

  task automatic test_logic();
    vec_t tbl[6];
    tbl = '{
      '{4'd0, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 4'b0100},
      '{4'd1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, 4'b0000},
      '{4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0010},
      '{4'd3, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100},
      '{4'd4, 32'h1234_5678, 32'hFFFF_FFFF, 32'hEDCB_A987, 4'b0100},
      '{4'd5, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b0100}
    };
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      nTests++;
      if (obs() !== {1'b1, tbl[i].y, tbl[i].f}) begin
        nFail++;
        $display("[TB] FAIL logic[%0d]: got %h want %h", i, obs(), {1'b1, tbl[i].y, tbl[i].f});
      end
    end
  endtask

  task automatic test_add();
    vec_t tbl[3];
    tbl = '{
      '{4'd6, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 4'b0000},
      '{4'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010},
      '{4'd6, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101}
    };
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      nTests++;
      if (obs() !== {1'b1, tbl[i].y, tbl[i].f}) begin
        nFail++;
        $display("[TB] FAIL add[%0d]: got %h want %h", i, obs(), {1'b1, tbl[i].y, tbl[i].f});
      end
    end
  endtask

  task automatic test_sub();
    vec_t tbl[3];
    tbl = '{
      '{4'd7, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010},
      '{4'd7, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 4'b0100},
      '{4'd7, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b1001}
    };
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      nTests++;
      if (obs() !== {1'b1, tbl[i].y, tbl[i].f}) begin
        nFail++;
        $display("[TB] FAIL sub[%0d]: got %h want %h", i, obs(), {1'b1, tbl[i].y, tbl[i].f});
      end
    end
  endtask

  task automatic test_cmp();
    vec_t tbl[4];
    tbl = '{
      '{4'd10, 32'h0000_0003, 32'h0000_0003, 32'h0000_0000, 4'b0010},
      '{4'd10, 32'h0000_0004, 32'h0000_0003, 32'h0000_0001, 4'b0000},
      '{4'd10, 32'h0000_0003, 32'h0000_0004, 32'hFFFF_FFFF, 4'b0100},
      '{4'd10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000}
    };
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      nTests++;
      if (obs() !== {1'b1, tbl[i].y, tbl[i].f}) begin
        nFail++;
        $display("[TB] FAIL cmp[%0d]: got %h want %h", i, obs(), {1'b1, tbl[i].y, tbl[i].f});
      end
    end
  endtask

  task automatic test_rotshift();
    vec_t tbl[8];
    tbl = '{
      '{4'd11, 32'h8000_0001, 32'd1,  32'h0000_0003, 4'b0000},
      '{4'd11, 32'hDEAD_BEEF, 32'd32, 32'hDEAD_BEEF, 4'b0100},
      '{4'd12, 32'h0000_0001, 32'd4,  32'h1000_0000, 4'b0000},
      '{4'd12, 32'hDEAD_BEEF, 32'd36, 32'hFDEA_DBEE, 4'b0100},
      '{4'd8,  32'h0000_0001, 32'd40, 32'h0000_0000, 4'b0010},
      '{4'd8,  32'h0000_0001, 32'd31, 32'h8000_0000, 4'b0100},
      '{4'd9,  32'h8000_0000, 32'd31, 32'h0000_0001, 4'b0000},
      '{4'd9,  32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 4'b0010}
    };
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b);
      nTests++;
      if (obs() !== {1'b1, tbl[i].y, tbl[i].f}) begin
        nFail++;
        $display("[TB] FAIL rotshift[%0d]: got %h want %h", i, obs(), {1'b1, tbl[i].y, tbl[i].f});
      end
    end
  endtask

  task automatic test_back_to_back();
    in_valid    = 1'b1;
    alu_control = 4'd6;
    a           = 32'h8000_0000;
    b           = 32'h8000_0000;
    @(posedge clk);
    #1;
    alu_control = 4'd0;
    a           = 32'h1234_0000;
    b           = 32'h0000_5678;
    nTests++;
    if (obs() !== {1'b1, 32'h0, 4'b1011}) begin
      nFail++;
      $display("[TB] FAIL stream_add: got %h want %h", obs(), {1'b1, 32'h0, 4'b1011});
    end
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    alu_control = 4'd6;
    a           = 32'h1;
    b           = 32'h1;
    nTests++;
    if (obs() !== {1'b1, 32'h1234_5678, 4'b0000}) begin
      nFail++;
      $display("[TB] FAIL stream_or: got %h want %h", obs(), {1'b1, 32'h1234_5678, 4'b0000});
    end
    @(posedge clk);
    #1;
    nTests++;
    if (obs() !== {1'b0, 32'h1234_5678, 4'b0000}) begin
      nFail++;
      $display("[TB] FAIL stream_idle: got %h want %h", obs(), {1'b0, 32'h1234_5678, 4'b0000});
    end
    issue(4'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    nTests++;
    if (obs() !== {1'b1, 32'h0, 4'b0010}) begin
      nFail++;
      $display("[TB] FAIL undef_op: got %h want %h", obs(), {1'b1, 32'h0, 4'b0010});
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    alu_control = 4'd0;
    a           = 32'h0;
    b           = 32'h0;
    #1;
    test_reset();
    test_logic();
    test_add();
    test_sub();
    test_cmp();
    test_rotshift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
